gd_controller: RTL

GD_CONTROLLER -- requirements
Module: gd_controller

---
 rtl/gd_pkg.sv | 40 ++++
 rtl/gd_update_unit.sv | 28 ++
 rtl/gd_controller.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/gd_pkg.sv
// Shared widths, saturation limits, FSM states and saturation helper for the gradient-descent controller.
package gd_pkg;

    localparam int unsigned Q_W    = 16;        // Q8.8 coordinate width
    localparam int unsigned Z_W    = 32;        // Q24.8 function value width
    localparam int unsigned DIFF_W = Z_W + 1;   // signed difference of two Z values
    localparam int unsigned N_DIM  = 4;
    localparam int unsigned P_W    = 3;         // probe index 0..4
    localparam int unsigned LR_W   = 4;

    localparam logic signed [Q_W-1:0]    SAT_MAX   = 16'sh7FFF;
    localparam logic signed [Q_W-1:0]    SAT_MIN   = 16'sh8000;
    localparam logic signed [DIFF_W-1:0] SAT_MAX_W = DIFF_W'(SAT_MAX);
    localparam logic signed [DIFF_W-1:0] SAT_MIN_W = DIFF_W'(SAT_MIN);

    localparam logic [Q_W-1:0] H_STEP_DEFAULT = 16'h0040;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_DONE,
        ST_WAIT_CLR,
        ST_UPDATE,
        ST_FINISH
    } state_t;

    // Clamp a wide signed value into the Q8.8 range.
    function automatic logic signed [Q_W-1:0] sat16(input logic signed [DIFF_W-1:0] v);
        logic signed [Q_W-1:0] r;
        if (v > SAT_MAX_W) begin
            r = SAT_MAX;
        end else if (v < SAT_MIN_W) begin
            r = SAT_MIN;
        end else begin
            r = v[Q_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/gd_update_unit.sv
// One-dimension gradient step: delta = sat16((z_k - z_0) >>> lr), x' = sat16(x - delta).
module gd_update_unit
    import gd_pkg::*;
(
    input  logic signed [Q_W-1:0]  i_x,
    input  logic signed [Z_W-1:0]  i_z_k,
    input  logic signed [Z_W-1:0]  i_z_0,
    input  logic        [LR_W-1:0] i_lr_shift,
    output logic signed [Q_W-1:0]  o_x_next_c,
    output logic                   o_delta_zero_c
);

    logic signed [DIFF_W-1:0] w_diff;
    logic signed [DIFF_W-1:0] w_shifted;
    logic signed [Q_W-1:0]    w_delta;
    logic signed [Q_W:0]      w_sub;

    // Finite-difference slope, scaled by the learning rate, then applied with saturation.
    always_comb begin
        w_diff         = DIFF_W'(i_z_k) - DIFF_W'(i_z_0);
        w_shifted      = w_diff >>> i_lr_shift;
        w_delta        = sat16(w_shifted);
        w_sub          = (Q_W+1)'(i_x) - (Q_W+1)'(w_delta);
        o_x_next_c     = sat16(DIFF_W'(w_sub));
        o_delta_zero_c = (w_delta == '0);
    end

endmodule

// File: rtl/gd_controller.sv
// Gradient-descent controller: probes an external evaluator at x and x+h*e_k, then steps x downhill.
module gd_controller
    import gd_pkg::*;
#(
    parameter logic [Q_W-1:0] H_STEP = H_STEP_DEFAULT,
    parameter int unsigned    ITER_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic signed [Q_W-1:0]    a_init,
    input  logic signed [Q_W-1:0]    b_init,
    input  logic signed [Q_W-1:0]    c_init,
    input  logic signed [Q_W-1:0]    d_init,
    input  logic        [LR_W-1:0]   lr_shift,
    input  logic        [ITER_W-1:0] max_iter,
    output logic                     eval_start,
    output logic signed [Q_W-1:0]    eval_a,
    output logic signed [Q_W-1:0]    eval_b,
    output logic signed [Q_W-1:0]    eval_c,
    output logic signed [Q_W-1:0]    eval_d,
    input  logic signed [Z_W-1:0]    eval_z,
    input  logic                     eval_done,
    input  logic                     eval_overflow,
    output logic signed [Q_W-1:0]    a_out,
    output logic signed [Q_W-1:0]    b_out,
    output logic signed [Q_W-1:0]    c_out,
    output logic signed [Q_W-1:0]    d_out,
    output logic signed [Z_W-1:0]    z_out,
    output logic        [ITER_W-1:0] iter_count,
    output logic                     busy,
    output logic                     done,
    output logic                     converged,
    output logic                     err
);

    state_t                  r_state;
    state_t                  w_state_next;
    logic signed [Q_W-1:0]   r_x      [N_DIM];
    logic signed [Q_W-1:0]   r_probe  [N_DIM];
    logic signed [Q_W-1:0]   w_probe  [N_DIM];
    logic signed [Q_W+1:0]   w_sum    [N_DIM];
    logic signed [Q_W-1:0]   w_x_next [N_DIM];
    logic        [N_DIM-1:0] w_delta_zero;
    logic                    w_all_zero;
    logic signed [Z_W-1:0]   r_z      [N_DIM+1];
    logic        [P_W-1:0]   r_p;
    logic        [LR_W-1:0]  r_lr;
    logic        [ITER_W-1:0] r_max;
    logic        [ITER_W-1:0] r_iter;
    logic                    r_eval_start;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_conv;
    logic                    r_err;
    logic                    r_clr_seen;
    logic signed [Z_W-1:0]   r_z_out;

    // Probe point for the current index: base point, or one coordinate nudged up with saturation.
    always_comb begin
        for (int k = 0; k < N_DIM; k++) begin
            w_sum[k]   = (Q_W+2)'(r_x[k]) + (Q_W+2)'({1'b0, H_STEP});
            w_probe[k] = r_x[k];
            if (r_p == P_W'(k + 1)) begin
                if (w_sum[k] > (Q_W+2)'(SAT_MAX)) begin
                    w_probe[k] = SAT_MAX;
                end else begin
                    w_probe[k] = w_sum[k][Q_W-1:0];
                end
            end
        end
    end

    for (genvar k = 0; k < N_DIM; k++) begin : g_upd
        gd_update_unit u_upd (
            .i_x            (r_x[k]),
            .i_z_k          (r_z[k+1]),
            .i_z_0          (r_z[0]),
            .i_lr_shift     (r_lr),
            .o_x_next_c     (w_x_next[k]),
            .o_delta_zero_c (w_delta_zero[k])
        );
    end

    assign w_all_zero = &w_delta_zero;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start && r_clr_seen) begin
                    w_state_next = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                w_state_next = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (eval_done) begin
                    w_state_next = ST_WAIT_CLR;
                end
            end
            ST_WAIT_CLR: begin
                if (!eval_done) begin
                    if (r_err) begin
                        w_state_next = ST_FINISH;
                    end else if ((r_p == '0) && (r_iter == r_max)) begin
                        w_state_next = ST_FINISH;
                    end else if (r_p == P_W'(N_DIM)) begin
                        w_state_next = ST_UPDATE;
                    end else begin
                        w_state_next = ST_LAUNCH;
                    end
                end
            end
            ST_UPDATE: begin
                if (w_all_zero || ((r_iter + ITER_W'(1)) == r_max)) begin
                    w_state_next = ST_FINISH;
                end else begin
                    w_state_next = ST_LAUNCH;
                end
            end
            ST_FINISH: begin
                if (!start) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Datapath and status registers, advanced alongside the state machine.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < N_DIM; k++) begin
                r_x[k]     <= '0;
                r_probe[k] <= '0;
            end
            for (int j = 0; j <= N_DIM; j++) begin
                r_z[j] <= '0;
            end
            r_p          <= '0;
            r_lr         <= '0;
            r_max        <= '0;
            r_iter       <= '0;
            r_eval_start <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_conv       <= 1'b0;
            r_err        <= 1'b0;
            r_clr_seen   <= 1'b0;
            r_z_out      <= '0;
        end else begin
            if (!eval_done) begin
                r_clr_seen <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_state_next == ST_LAUNCH) begin
                        r_x[0] <= a_init;
                        r_x[1] <= b_init;
                        r_x[2] <= c_init;
                        r_x[3] <= d_init;
                        r_lr   <= lr_shift;
                        r_max  <= max_iter;
                        r_iter <= '0;
                        r_p    <= '0;
                        r_busy <= 1'b1;
                        r_done <= 1'b0;
                        r_conv <= 1'b0;
                        r_err  <= 1'b0;
                    end
                end
                ST_LAUNCH: begin
                    for (int k = 0; k < N_DIM; k++) begin
                        r_probe[k] <= w_probe[k];
                    end
                    r_eval_start <= 1'b1;
                end
                ST_WAIT_DONE: begin
                    if (eval_done) begin
                        r_eval_start <= 1'b0;
                        if (eval_overflow) begin
                            r_err <= 1'b1;
                        end else begin
                            for (int j = 0; j <= N_DIM; j++) begin
                                if (r_p == P_W'(j)) begin
                                    r_z[j] <= eval_z;
                                end
                            end
                            if (r_p == '0) begin
                                r_z_out <= eval_z;
                            end
                        end
                    end
                end
                ST_WAIT_CLR: begin
                    if (w_state_next == ST_LAUNCH) begin
                        r_p <= r_p + P_W'(1);
                    end
                end
                ST_UPDATE: begin
                    for (int k = 0; k < N_DIM; k++) begin
                        r_x[k] <= w_x_next[k];
                    end
                    r_iter <= r_iter + ITER_W'(1);
                    r_p    <= '0;
                    if (w_all_zero) begin
                        r_conv <= 1'b1;
                    end
                end
                ST_FINISH: begin
                    if (w_state_next == ST_IDLE) begin
                        r_done <= 1'b0;
                        r_conv <= 1'b0;
                        r_err  <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
            if ((w_state_next == ST_FINISH) && (r_state != ST_FINISH)) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

    assign eval_start = r_eval_start;
    assign eval_a     = r_probe[0];
    assign eval_b     = r_probe[1];
    assign eval_c     = r_probe[2];
    assign eval_d     = r_probe[3];
    assign a_out      = r_x[0];
    assign b_out      = r_x[1];
    assign c_out      = r_x[2];
    assign d_out      = r_x[3];
    assign z_out      = r_z_out;
    assign iter_count = r_iter;
    assign busy       = r_busy;
    assign done       = r_done;
    assign converged  = r_conv;
    assign err        = r_err;

endmodule
